// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between an instruction cache and a data cache.
// One line transaction is in flight at a time. Data requests beat instruction requests, and a
// data read+write collision is issued as a write. Each transaction passes IDLE -> SERVE_x ->
// DONE -> IDLE. The command is latched when the transaction is granted, so requester inputs
// may change while it is in flight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_read, i_addr              instruction-cache fill request
//   i_rdata, i_resp             line returned to I-cache, one-cycle completion pulse
//   d_read, d_write             data-cache fill / writeback request
//   d_addr, d_wdata             data request address and writeback line
//   d_rdata, d_resp             line returned to D-cache, one-cycle completion pulse
//   pmem_read, pmem_write       physical memory command
//   pmem_addr, pmem_wdata       physical memory address and write line
//   pmem_rdata, pmem_resp       physical memory read line and completion
//   grant                       current owner: 00 none, 01 instruction, 10 data
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_d_req;
  logic w_grant_edge;

  assign w_d_req      = d_read | d_write;
  assign w_grant_edge = (r_state == StIdle) && (w_state_next != StIdle);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; pmem_resp outside SERVE_x has no effect
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_d_req) begin
          w_state_next = StServeD;
        end else if (i_read) begin
          w_state_next = StServeI;
        end
      end
      StServeI: if (pmem_resp) w_state_next = StDone;
      StServeD: if (pmem_resp) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Command latch and returned-line capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant_edge) begin
        if (w_d_req) begin
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
          // A simultaneous read+write is issued as the writeback
          r_write <= d_write;
        end else begin
          r_addr  <= i_addr;
          r_wdata <= '0;
          r_write <= 1'b0;
        end
      end
      if (i_resp) begin
        r_i_rdata <= pmem_rdata;
      end
      if (d_resp && !r_write) begin
        r_d_rdata <= pmem_rdata;
      end
    end
  end

  // Address and write line come only from the latch so they stay stable while serving
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;

  // Output logic
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    grant      = 2'b00;
    i_rdata    = r_i_rdata;
    d_rdata    = r_d_rdata;
    unique case (r_state)
      StServeI: begin
        grant     = 2'b01;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
        end
      end
      StServeD: begin
        grant      = 2'b10;
        pmem_read  = !r_write;
        pmem_write = r_write;
        if (pmem_resp) begin
          d_resp = 1'b1;
          if (!r_write) begin
            d_rdata = pmem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  localparam logic [LW-1:0] LINE_A5 = {8{32'hA5A5_A5A5}};
  localparam logic [LW-1:0] LINE_D1 = {8{32'hD1D1_0001}};
  localparam logic [LW-1:0] LINE_I2 = {8{32'h1212_0002}};
  localparam logic [LW-1:0] LINE_WB = {8{32'h1234_5678}};
  localparam logic [LW-1:0] LINE_JK = {8{32'hDEAD_BEEF}};

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    grant;

  int n_pass;
  int n_total;
  int i_pulses;
  int d_pulses;

  cache_arbiter #(
    .LINE_W(LW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .pmem_addr (pmem_addr),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp (pmem_resp),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses as seen at each rising edge
  initial begin
    i_pulses = 0;
    d_pulses = 0;
  end
  always @(posedge clk) begin
    if (i_resp) i_pulses <= i_pulses + 1;
    if (d_resp) d_pulses <= d_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock; inputs are driven 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_total++;
    if (grant !== 2'b00) $display("FAIL reset_grant got %b exp 00", grant);
    else n_pass++;
    n_total++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
      $display("FAIL reset_ctrl got %b exp 0000", {pmem_read, pmem_write, i_resp, d_resp});
    else n_pass++;
    n_total++;
    if (pmem_addr !== '0) $display("FAIL reset_addr got %h exp 0", pmem_addr);
    else n_pass++;
    n_total++;
    if (i_rdata !== '0 || d_rdata !== '0) $display("FAIL reset_rdata got %h/%h exp 0", i_rdata, d_rdata);
    else n_pass++;
  endtask

  task automatic test_single_fill();
    int i0;
    i0 = i_pulses;
    i_read = 1'b1;
    i_addr = 32'h0000_1000;
    #1;
    n_total++;
    if (pmem_read !== 1'b0) $display("FAIL fill_idle_read got %b exp 0", pmem_read);
    else n_pass++;
    tick();
    i_read = 1'b0;   // dropping the request must not abort the fill
    i_addr = 32'hFFFF_FFFF;
    #1;
    n_total++;
    if (grant !== 2'b01) $display("FAIL fill_grant got %b exp 01", grant);
    else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      n_total++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h0000_1000 || i_resp !== 1'b0)
        $display("FAIL fill_cycle%0d got rd=%b wr=%b addr=%h resp=%b exp 1 0 00001000 0",
                 c, pmem_read, pmem_write, pmem_addr, i_resp);
      else n_pass++;
      tick();
    end
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_A5;
    #1;
    n_total++;
    if (pmem_read !== 1'b1 || i_resp !== 1'b1 || i_rdata !== LINE_A5 || d_resp !== 1'b0)
      $display("FAIL fill_resp got rd=%b iresp=%b dresp=%b rdata=%h", pmem_read, i_resp, d_resp, i_rdata);
    else n_pass++;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    n_total++;
    if (grant !== 2'b00 || pmem_read !== 1'b0 || i_resp !== 1'b0)
      $display("FAIL fill_done got grant=%b rd=%b resp=%b exp 00 0 0", grant, pmem_read, i_resp);
    else n_pass++;
    n_total++;
    if (i_rdata !== LINE_A5) $display("FAIL fill_hold_rdata got %h exp %h", i_rdata, LINE_A5);
    else n_pass++;
    tick();
    n_total++;
    if (i_pulses - i0 !== 1) $display("FAIL fill_pulses got %0d exp 1", i_pulses - i0);
    else n_pass++;
  endtask

  task automatic test_collision();
    int i0;
    int d0;
    i0 = i_pulses;
    d0 = d_pulses;
    i_read = 1'b1;
    i_addr = 32'h0000_3000;
    d_read = 1'b1;
    d_addr = 32'h0000_2000;
    tick();
    n_total++;
    if (grant !== 2'b10 || pmem_addr !== 32'h0000_2000 || pmem_read !== 1'b1)
      $display("FAIL coll_first got grant=%b addr=%h rd=%b exp 10 00002000 1", grant, pmem_addr, pmem_read);
    else n_pass++;
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_D1;
    #1;
    n_total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== LINE_D1)
      $display("FAIL coll_dresp got d=%b i=%b rdata=%h", d_resp, i_resp, d_rdata);
    else n_pass++;
    tick();
    d_read     = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    n_total++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || grant !== 2'b00)
      $display("FAIL coll_gap1 got rd=%b wr=%b grant=%b exp 0 0 00", pmem_read, pmem_write, grant);
    else n_pass++;
    tick();
    n_total++;
    if (pmem_read !== 1'b0 || grant !== 2'b00)
      $display("FAIL coll_gap2 got rd=%b grant=%b exp 0 00", pmem_read, grant);
    else n_pass++;
    tick();
    n_total++;
    if (grant !== 2'b01 || pmem_addr !== 32'h0000_3000 || pmem_read !== 1'b1)
      $display("FAIL coll_second got grant=%b addr=%h rd=%b exp 01 00003000 1", grant, pmem_addr, pmem_read);
    else n_pass++;
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_I2;
    #1;
    n_total++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== LINE_I2)
      $display("FAIL coll_iresp got i=%b d=%b rdata=%h", i_resp, d_resp, i_rdata);
    else n_pass++;
    tick();
    i_read    = 1'b0;
    pmem_resp = 1'b0;
    tick();
    n_total++;
    if (d_rdata !== LINE_D1) $display("FAIL coll_d_hold got %h exp %h", d_rdata, LINE_D1);
    else n_pass++;
    n_total++;
    if (i_pulses - i0 !== 1 || d_pulses - d0 !== 1)
      $display("FAIL coll_pulses got i=%0d d=%0d exp 1 1", i_pulses - i0, d_pulses - d0);
    else n_pass++;
  endtask

  task automatic test_writeback();
    int d0;
    d0 = d_pulses;
    d_write = 1'b1;
    d_addr  = 32'h0000_4040;
    d_wdata = LINE_WB;
    tick();
    d_addr  = 32'h0000_5000;
    d_wdata = '0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h0000_4040 ||
          pmem_wdata !== LINE_WB)
        $display("FAIL wb_cycle%0d got wr=%b rd=%b addr=%h wdata=%h", c, pmem_write, pmem_read,
                 pmem_addr, pmem_wdata);
      else n_pass++;
      tick();
    end
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_JK;
    #1;
    n_total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) $display("FAIL wb_resp got d=%b i=%b exp 1 0", d_resp, i_resp);
    else n_pass++;
    tick();
    d_write    = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    n_total++;
    if (pmem_write !== 1'b0 || d_resp !== 1'b0) $display("FAIL wb_done got wr=%b resp=%b exp 0 0", pmem_write, d_resp);
    else n_pass++;
    tick();
    n_total++;
    if (d_pulses - d0 !== 1) $display("FAIL wb_pulses got %0d exp 1", d_pulses - d0);
    else n_pass++;
  endtask

  task automatic test_read_write_both();
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_6000;
    d_wdata = LINE_A5;
    tick();
    n_total++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h0000_6000)
      $display("FAIL both_cmd got wr=%b rd=%b addr=%h exp 1 0 00006000", pmem_write, pmem_read, pmem_addr);
    else n_pass++;
    pmem_resp = 1'b1;
    tick();
    d_read    = 1'b0;
    d_write   = 1'b0;
    pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = d_pulses;
    d_read = 1'b1;
    d_addr = 32'h0000_7000;
    tick();
    n_total++;
    if (grant !== 2'b10) $display("FAIL rmid_grant got %b exp 10", grant);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    d_read = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_JK;
    #1;
    n_total++;
    if (grant !== 2'b00 || {pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
      $display("FAIL rmid_outputs got grant=%b ctrl=%b exp 00 0000", grant,
               {pmem_read, pmem_write, i_resp, d_resp});
    else n_pass++;
    n_total++;
    if (pmem_addr !== '0 || pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0)
      $display("FAIL rmid_regs got addr=%h rdata=%h/%h exp 0", pmem_addr, i_rdata, d_rdata);
    else n_pass++;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    n_total++;
    if (grant !== 2'b00 || d_pulses - d0 !== 0)
      $display("FAIL rmid_no_resp got grant=%b pulses=%0d exp 00 0", grant, d_pulses - d0);
    else n_pass++;
  endtask

  task automatic test_spurious_resp();
    int i0;
    int d0;
    i0 = i_pulses;
    d0 = d_pulses;
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_JK;
    #1;
    n_total++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || grant !== 2'b00)
      $display("FAIL spur_idle got i=%b d=%b grant=%b exp 0 0 00", i_resp, d_resp, grant);
    else n_pass++;
    tick();
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    n_total++;
    if (grant !== 2'b00 || pmem_read !== 1'b0 || i_pulses - i0 !== 0 || d_pulses - d0 !== 0)
      $display("FAIL spur_after got grant=%b rd=%b pulses=%0d/%0d exp 00 0 0/0", grant, pmem_read,
               i_pulses - i0, d_pulses - d0);
    else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    tick();
    test_reset();
    test_single_fill();
    test_collision();
    test_writeback();
    test_read_write_both();
    test_reset_mid();
    test_spurious_resp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
